// File: rtl/ara_pkg.sv
// ara_pkg: shared transaction-controller state type and default outstanding limits
package ara_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DRAIN} txn_state_e;
  localparam int unsigned DefMaxRdTxn = 8;
  localparam int unsigned DefMaxWrTxn = 8;
  localparam int unsigned TxnCntW = 8;
endpackage

// File: rtl/vlsu_txn_counter.sv
// vlsu_txn_counter: saturating up/down outstanding-burst counter with underflow pulse
module vlsu_txn_counter import ara_pkg::*; #(
  parameter int unsigned Max = DefMaxRdTxn
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [TxnCntW-1:0] cnt_o,
  output logic               err_o
);
  logic [TxnCntW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // a simultaneous issue and completion cancel out, even at zero
  always_comb begin
    err_d = dec_i & ~inc_i & (cnt_q == '0);
    cnt_d = (inc_i & ~dec_i & (cnt_q < TxnCntW'(Max))) ? cnt_q + 1'b1 :
            (dec_i & ~inc_i & (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign cnt_o = cnt_q;
  assign err_o = err_q;
endmodule

// File: rtl/vlsu_txn_ctrl.sv
// vlsu_txn_ctrl: limits outstanding AXI read/write bursts and optionally serialises loads vs stores
module vlsu_txn_ctrl import ara_pkg::*; #(
  parameter int unsigned MaxRdTxn = DefMaxRdTxn,
  parameter int unsigned MaxWrTxn = DefMaxWrTxn,
  parameter type axi_ar_t = logic,
  parameter type axi_aw_t = logic
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ord_i,
  input  axi_ar_t            slv_ar_i,
  input  logic               slv_ar_valid_i,
  output logic               slv_ar_ready_o,
  output axi_ar_t            mst_ar_o,
  output logic               mst_ar_valid_o,
  input  logic               mst_ar_ready_i,
  input  axi_aw_t            slv_aw_i,
  input  logic               slv_aw_valid_i,
  output logic               slv_aw_ready_o,
  output axi_aw_t            mst_aw_o,
  output logic               mst_aw_valid_o,
  input  logic               mst_aw_ready_i,
  input  logic               r_valid_i,
  input  logic               r_ready_i,
  input  logic               r_last_i,
  input  logic               b_valid_i,
  input  logic               b_ready_i,
  output logic [TxnCntW-1:0] rd_cnt_o,
  output logic [TxnCntW-1:0] wr_cnt_o,
  output logic               idle_o,
  output logic               err_o
);
  txn_state_e state_q, state_d;
  logic rd_ok, wr_ok, ar_en, aw_en, ar_hs, aw_hs, rd_err, wr_err;
  assign mst_ar_o = slv_ar_i;
  assign mst_aw_o = slv_aw_i;
  // in IDLE a grantable AR pre-empts AW so loads win simultaneous requests
  always_comb begin
    rd_ok = rd_cnt_o < TxnCntW'(MaxRdTxn);
    wr_ok = wr_cnt_o < TxnCntW'(MaxWrTxn);
    ar_en = ~ord_i ? rd_ok : rd_ok & (state_q == IDLE || state_q == RD);
    aw_en = ~ord_i ? wr_ok : wr_ok & ((state_q == WR) |
            ((state_q == IDLE) & ~(slv_ar_valid_i & rd_ok)));
    mst_ar_valid_o = slv_ar_valid_i & ar_en & ~rst_i;
    slv_ar_ready_o = mst_ar_ready_i & ar_en & ~rst_i;
    mst_aw_valid_o = slv_aw_valid_i & aw_en & ~rst_i;
    slv_aw_ready_o = mst_aw_ready_i & aw_en & ~rst_i;
    ar_hs = mst_ar_valid_o & mst_ar_ready_i;
    aw_hs = mst_aw_valid_o & mst_aw_ready_i;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ar_hs ? RD : aw_hs ? WR : IDLE;
      RD:      state_d = slv_aw_valid_i ? DRAIN :
                         (rd_cnt_o == '0 && !slv_ar_valid_i) ? IDLE : RD;
      WR:      state_d = slv_ar_valid_i ? DRAIN :
                         (wr_cnt_o == '0 && !slv_aw_valid_i) ? IDLE : WR;
      default: state_d = (rd_cnt_o == '0 && wr_cnt_o == '0) ? IDLE : DRAIN;
    endcase
    if (!ord_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end
  vlsu_txn_counter #(.Max(MaxRdTxn)) i_rd_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ar_hs),
    .dec_i (r_valid_i & r_ready_i & r_last_i),
    .cnt_o (rd_cnt_o),
    .err_o (rd_err)
  );
  vlsu_txn_counter #(.Max(MaxWrTxn)) i_wr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (aw_hs),
    .dec_i (b_valid_i & b_ready_i),
    .cnt_o (wr_cnt_o),
    .err_o (wr_err)
  );
  assign idle_o = (state_q == IDLE) && (rd_cnt_o == '0) && (wr_cnt_o == '0);
  assign err_o  = rd_err | wr_err;
endmodule
